// File: rtl/xps2_rx_pkg.sv
// Shared definitions for the PS/2 receive front-end.
// This covers the frame states, the frame geometry and the data_out field layout.
package xps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rxState_e;

    localparam int FRAME_LEN     = 11;
    localparam int DATA_BITS     = FRAME_LEN - 3;
    localparam int DOUT_VALID    = 8;
    localparam int DOUT_CODE_MSB = 7;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic oddParityOk(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/xps2_filt.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 pin.
// It also produces a one-cycle pulse when the filtered level falls.
module xps2_filt #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // The filtered level flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_q <= sync2_q;
                fall_q <= filt_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: it deserialises and checks frames, then queues good scancodes.
// The controller bus reads the queue through data_out and clears the sticky flags by writing.
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int FIFO_AW     = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       sel,
    input  logic       we,
    input  logic [1:0] data_in,
    output logic [8:0] data_out,
    output logic       frame_err,
    output logic       ovf
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic unusedClkLevel;
    logic unusedDataFall;
    logic clkFall;
    logic dataFilt;

    xps2_filt #(.FILT_LEN(FILT_LEN)) u_clkFilt (
        .clk_i  (clk),
        .rst_ni (rst),
        .pin_i  (ps2_clk),
        .filt_o (unusedClkLevel),
        .fall_o (clkFall)
    );

    xps2_filt #(.FILT_LEN(FILT_LEN)) u_dataFilt (
        .clk_i  (clk),
        .rst_ni (rst),
        .pin_i  (ps2_data),
        .filt_o (dataFilt),
        .fall_o (unusedDataFall)
    );

    rxState_e         state_q;
    logic [2:0]       bitCnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TO_W-1:0]  toCnt_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q;
    logic [FIFO_AW-1:0] rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               frameErr_q;
    logic               ovf_q;

    logic stopSeen, goodFrame, timeoutHit;
    logic empty, full, pop, push, ovfSet, errSet, wrClr;

    assign stopSeen   = clkFall && (state_q == ST_STOP);
    assign goodFrame  = stopSeen && dataFilt && oddParityOk(shift_q, parity_q);
    assign timeoutHit = (state_q != ST_IDLE) && !clkFall && (toCnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign pop        = sel && !we && !empty;
    // A pop in the push cycle frees the head slot, so a full FIFO can still accept the byte.
    assign push       = goodFrame && (!full || pop);
    assign ovfSet     = goodFrame && full && !pop;
    assign errSet     = (stopSeen && !goodFrame) || timeoutHit;
    assign wrClr      = sel && we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            toCnt_q  <= '0;
        end else if (timeoutHit) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            toCnt_q  <= '0;
        end else begin
            if (clkFall || state_q == ST_IDLE) begin
                toCnt_q <= '0;
            end else begin
                toCnt_q <= toCnt_q + 1'b1;
            end
            if (clkFall) begin
                case (state_q)
                    ST_IDLE: begin
                        bitCnt_q <= '0;
                        if (!dataFilt) state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        shift_q <= {dataFilt, shift_q[7:1]};
                        if (bitCnt_q == 3'(DATA_BITS - 1)) begin
                            bitCnt_q <= '0;
                            state_q  <= ST_PARITY;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dataFilt;
                        state_q  <= ST_STOP;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // A flag set event in the same cycle as a bus clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            frameErr_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q    <= count_d;
            frameErr_q <= errSet || (frameErr_q && !(wrClr && data_in[0]));
            ovf_q      <= ovfSet || (ovf_q && !(wrClr && data_in[1]));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= shift_q;
    end

    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out[DOUT_VALID]        = 1'b1;
            data_out[DOUT_CODE_MSB:0]   = mem_q[rdPtr_q];
        end
    end

    assign frame_err = frameErr_q;
    assign ovf       = ovf_q;

endmodule
